// File: rtl/spi_accel_responder.sv
// SPI mode-0 responder emulating the ADXL362 register protocol (ID, X/Y/Z, config window).
// Optional DATA_READY status bit is enabled by defining SPI_RESP_STATUS_EN.
module spi_accel_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID       = 8'hAD,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic               ClkPort,
  input  logic               Reset,
  input  logic               sclk,
  input  logic               ss,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic signed [11:0] accel_x,
  input  logic signed [11:0] accel_y,
  input  logic signed [11:0] accel_z,
  input  logic               sample_strobe,
  output logic               wr_strobe,
  output logic [7:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  function automatic logic [7:0] hi_byte(input logic signed [11:0] v);
    return {{4{v[11]}}, v[11:8]};
  endfunction

  function automatic logic [7:0] read_reg(
    input logic [7:0]         a,
    input logic signed [11:0] x,
    input logic signed [11:0] y,
    input logic signed [11:0] z,
    input logic [7:0]         st,
    input logic [7:0]         cfg_word
  );
    logic [7:0] d;
    d = 8'h00;
    if (a[7:4] == 4'h2) begin
      d = cfg_word;
    end else begin
      case (a)
        8'h00:   d = DEVID;
        8'h01:   d = 8'h1D;
        8'h02:   d = PARTID;
        8'h0B:   d = st;
        8'h0E:   d = x[7:0];
        8'h0F:   d = hi_byte(x);
        8'h10:   d = y[7:0];
        8'h11:   d = hi_byte(y);
        8'h12:   d = z[7:0];
        8'h13:   d = hi_byte(z);
        default: d = 8'h00;
      endcase
    end
    return d;
  endfunction

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_ss_prev;

  state_t            r_state;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_rx, r_tx, r_ptr;
  logic              r_is_wr;
  logic              r_miso, r_miso_oe, r_busy;
  logic              r_wr_strobe;
  logic [7:0]        r_wr_addr, r_wr_data;
  logic [7:0]        r_cfg [16];
  logic signed [11:0] r_snap_x, r_snap_y, r_snap_z;

  logic       w_sclk_s, w_ss_s, w_mosi_s;
  logic       w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic       w_byte_done;
  logic [7:0] w_byte, w_ptr_nxt, w_status;
  logic       w_snap_clr;

  // Synchronizer chains; ss idles high so reset it high to avoid a false select
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
      r_ss_prev   <= w_ss_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev & ~w_ss_s;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev & ~w_ss_s;
  assign w_ss_fall   = ~w_ss_s & r_ss_prev;
  assign w_ss_rise   = w_ss_s & ~r_ss_prev;
  assign w_byte_done = w_sclk_rise & (r_bitcnt == 3'd7);
  assign w_byte      = {r_rx[6:0], w_mosi_s};
  assign w_ptr_nxt   = r_ptr + 8'd1;
  assign w_snap_clr  = w_byte_done & (r_state == S_ADDR) & ~r_is_wr &
                       (w_byte >= 8'h0E) & (w_byte <= 8'h13);

`ifdef SPI_RESP_STATUS_EN
  logic r_data_ready;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset)              r_data_ready <= 1'b0;
    else if (sample_strobe) r_data_ready <= 1'b1;
    else if (w_snap_clr)    r_data_ready <= 1'b0;
  end

  assign w_status = {7'b0, r_data_ready};
`else
  logic w_unused_status;
  assign w_unused_status = sample_strobe ^ w_snap_clr;
  assign w_status        = 8'h00;
`endif

  // Protocol FSM; the 3-bit counter wraps to 0 at the eighth bit, closing each byte
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 3'd0;
      r_rx        <= 8'h00;
      r_tx        <= 8'h00;
      r_ptr       <= 8'h00;
      r_is_wr     <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 8'h00;
      r_wr_data   <= 8'h00;
      r_snap_x    <= '0;
      r_snap_y    <= '0;
      r_snap_z    <= '0;
      for (int i = 0; i < 16; i++) r_cfg[i] <= 8'h00;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_ss_rise) begin
        r_state   <= S_IDLE;
        r_bitcnt  <= 3'd0;
        r_busy    <= 1'b0;
        r_miso_oe <= 1'b0;
        r_miso    <= 1'b0;
      end else if (w_ss_fall) begin
        r_state   <= S_CMD;
        r_bitcnt  <= 3'd0;
        r_busy    <= 1'b1;
        r_miso_oe <= 1'b1;
        r_miso    <= 1'b0;
      end else if (w_sclk_rise) begin
        r_rx     <= w_byte;
        r_bitcnt <= r_bitcnt + 3'd1;
        if (w_byte_done) begin
          case (r_state)
            S_CMD: begin
              if (w_byte == CMD_WRITE) begin
                r_is_wr <= 1'b1;
                r_state <= S_ADDR;
              end else if (w_byte == CMD_READ) begin
                r_is_wr <= 1'b0;
                r_state <= S_ADDR;
              end else begin
                r_state <= S_IGNORE;
              end
            end
            S_ADDR: begin
              r_ptr    <= w_byte;
              r_snap_x <= accel_x;
              r_snap_y <= accel_y;
              r_snap_z <= accel_z;
              if (r_is_wr) begin
                r_state <= S_WDATA;
              end else begin
                r_state <= S_RDATA;
                // First byte comes from the live inputs being captured this cycle
                r_tx    <= read_reg(w_byte, accel_x, accel_y, accel_z, w_status,
                                    r_cfg[w_byte[3:0]]);
              end
            end
            S_WDATA: begin
              if (r_ptr[7:4] == 4'h2) begin
                r_cfg[r_ptr[3:0]] <= w_byte;
                r_wr_strobe       <= 1'b1;
                r_wr_addr         <= r_ptr;
                r_wr_data         <= w_byte;
              end
              r_ptr <= w_ptr_nxt;
            end
            S_RDATA: begin
              r_ptr <= w_ptr_nxt;
              r_tx  <= read_reg(w_ptr_nxt, r_snap_x, r_snap_y, r_snap_z, w_status,
                                r_cfg[w_ptr_nxt[3:0]]);
            end
            default: r_state <= r_state;
          endcase
        end
      end else if (w_sclk_fall && r_state == S_RDATA) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign miso      = r_miso;
  assign miso_oe   = r_miso_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Scoreboard bench for spi_accel_responder: a bit-banged SPI initiator feeds received bytes
// and write strobes to monitors that compare against expected-value queues.
module tb_spi_accel_responder;
  localparam int HALF = 40;

  logic               ClkPort = 1'b0;
  logic               Reset = 1'b1;
  logic               sclk = 1'b0;
  logic               ss = 1'b1;
  logic               mosi = 1'b0;
  logic               sample_strobe = 1'b0;
  logic signed [11:0] accel_x = '0;
  logic signed [11:0] accel_y = '0;
  logic signed [11:0] accel_z = '0;
  logic               miso, miso_oe, wr_strobe, busy;
  logic [7:0]         wr_addr, wr_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] wexp_q[$];
  logic [7:0]  rx_byte;
  event        rx_ev;

  spi_accel_responder dut (
    .ClkPort(ClkPort), .Reset(Reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .accel_x(accel_x), .accel_y(accel_y),
    .accel_z(accel_z), .sample_strobe(sample_strobe), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 ClkPort = ~ClkPort;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // Byte monitor: every byte clocked in from miso is checked against the scoreboard
  initial begin
    forever begin
      @(rx_ev);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL miso_byte: got %0h, expected no byte", rx_byte);
      end else begin
        chk("miso_byte", {24'h0, rx_byte}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Write monitor: every wr_strobe cycle must match a queued write
  always @(negedge ClkPort) begin
    if (!Reset && wr_strobe) begin
      if (wexp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_strobe: unexpected write addr %0h data %0h", wr_addr, wr_data);
      end else begin
        chk("wr_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, wexp_q.pop_front()});
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: bench did not finish, %0d bytes pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic spi_begin();
    ss = 1'b0;
    #(2*HALF);
  endtask

  task automatic spi_end();
    #HALF;
    ss   = 1'b1;
    mosi = 1'b0;
    #(4*HALF);
  endtask

  task automatic spi_bits(input logic [7:0] t, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = t[i];
      #HALF;
      r[i] = miso;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] t, input logic [7:0] e);
    logic [7:0] r;
    exp_q.push_back(e);
    spi_bits(t, 8, r);
    rx_byte = r;
    ->rx_ev;
  endtask

  task automatic rd(input logic [7:0] a, input int n,
                    input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    spi_begin();
    spi_byte(8'h0B, 8'h00);
    spi_byte(a, 8'h00);
    for (int i = 0; i < n; i++)
      spi_byte(8'h00, (i == 0) ? e0 : (i == 1) ? e1 : e2);
    spi_end();
  endtask

  task automatic wr(input logic [7:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1);
    spi_begin();
    spi_byte(8'h0A, 8'h00);
    spi_byte(a, 8'h00);
    spi_byte(d0, 8'h00);
    if (n > 1) spi_byte(d1, 8'h00);
    spi_end();
  endtask

  initial begin
    logic [7:0] junk;
    repeat (3) @(negedge ClkPort);
    chk("rst_miso", {31'h0, miso}, 32'h0);
    chk("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wr_strobe", {31'h0, wr_strobe}, 32'h0);
    chk("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
    chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
    Reset = 1'b0;
    repeat (5) @(negedge ClkPort);

    rd(8'h00, 1, 8'hAD, 8'h00, 8'h00);
    rd(8'h00, 3, 8'hAD, 8'h1D, 8'hF2);

    accel_x = 12'hF85;
    accel_y = 12'h7A5;
    accel_z = 12'h800;
    rd(8'h0E, 2, 8'h85, 8'hFF, 8'h00);
    rd(8'h12, 2, 8'h00, 8'hF8, 8'h00);

    // Sample changes mid-burst; snapshot keeps the returned bytes coherent
    spi_begin();
    spi_byte(8'h0B, 8'h00);
    spi_byte(8'h0E, 8'h00);
    spi_byte(8'h00, 8'h85);
    accel_x = 12'h123;
    spi_byte(8'h00, 8'hFF);
    spi_byte(8'h00, 8'hA5);
    chk("busy_in_txn", {31'h0, busy}, 32'h1);
    chk("oe_in_txn", {31'h0, miso_oe}, 32'h1);
    spi_end();
    chk("busy_idle", {31'h0, busy}, 32'h0);
    chk("oe_idle", {31'h0, miso_oe}, 32'h0);
    chk("miso_idle", {31'h0, miso}, 32'h0);

    wexp_q.push_back({8'h2D, 8'h02});
    wr(8'h2D, 1, 8'h02, 8'h00);
    rd(8'h2D, 1, 8'h02, 8'h00, 8'h00);

    wr(8'h00, 1, 8'h55, 8'h00);
    rd(8'h00, 1, 8'hAD, 8'h00, 8'h00);

    rd(8'hFF, 2, 8'h00, 8'hAD, 8'h00);

    wexp_q.push_back({8'h2F, 8'h11});
    wr(8'h2F, 2, 8'h11, 8'h22);
    rd(8'h2F, 2, 8'h11, 8'h00, 8'h00);
    rd(8'h20, 1, 8'h00, 8'h00, 8'h00);

    // Abort after five bits of write data
    spi_begin();
    spi_byte(8'h0A, 8'h00);
    spi_byte(8'h2C, 8'h00);
    spi_bits(8'hFF, 5, junk);
    chk("busy_partial", {31'h0, busy}, 32'h1);
    spi_end();
    chk("busy_after_abort", {31'h0, busy}, 32'h0);
    rd(8'h2C, 1, 8'h00, 8'h00, 8'h00);

    spi_begin();
    spi_byte(8'h55, 8'h00);
    spi_byte(8'h0E, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_end();
    rd(8'h01, 1, 8'h1D, 8'h00, 8'h00);

    @(negedge ClkPort);
    sample_strobe = 1'b1;
    @(negedge ClkPort);
    sample_strobe = 1'b0;
`ifdef SPI_RESP_STATUS_EN
    rd(8'h0B, 1, 8'h01, 8'h00, 8'h00);
    rd(8'h0E, 1, 8'h23, 8'h00, 8'h00);
    rd(8'h0B, 1, 8'h00, 8'h00, 8'h00);
`else
    rd(8'h0B, 1, 8'h00, 8'h00, 8'h00);
`endif

    repeat (10) @(negedge ClkPort);
    chk("miso_q_drained", exp_q.size(), 32'h0);
    chk("wr_q_drained", wexp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
